// File: rtl/rx_word_packer.sv
// rtl/rx_word_packer.sv - packs received bytes little-endian into words and queues them in a small FIFO
module rx_word_packer #(
  parameter int NB_DATA       = 8,
  parameter int NB_WORD       = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_tick,
  input  logic [NB_DATA-1:0]            i_data,
  input  logic                          i_valid,
  input  logic                          i_flush,
  output logic [NB_WORD-1:0]            o_word,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_drop,
  output logic                          o_timeout
);

  localparam int NB_BYTES = NB_WORD / NB_DATA;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int TMR_W    = $clog2(TIMEOUT_TICKS) + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NB_WORD-1:0] hold_q, hold_d;
  logic [NB_WORD-1:0] word_next;
  logic [NB_WORD-1:0] push_word;
  logic               push;
  logic               timeout_d, timeout_q;

  logic [NB_WORD-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               full, pop, wr_en, drop_d, drop_q;

  // Held bytes with the incoming byte dropped into the current slot.
  always_comb begin
    word_next = hold_q;
    for (int k = 0; k < NB_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        word_next[k*NB_DATA +: NB_DATA] = i_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_word = '0;
    timeout_d = 1'b0;
    if (i_flush) begin
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
      hold_d  = '0;
    end else if (i_valid) begin
      timer_d = '0;
      if (idx_q == LAST_IDX) begin
        push      = 1'b1;
        push_word = word_next;
        hold_d    = '0;
        idx_d     = '0;
        state_d   = IDLE;
      end else begin
        hold_d  = word_next;
        idx_d   = idx_q + IDX_W'(1);
        state_d = COLLECT;
      end
    end else if (state_q == COLLECT && i_tick) begin
      if (timer_q == TMR_LAST) begin
        timeout_d = 1'b1;
        hold_d    = '0;
        idx_d     = '0;
        timer_d   = '0;
        state_d   = IDLE;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign full   = (count_q == FULL_CNT);
  assign pop    = (count_q != '0) && i_word_ready && !i_flush;
  assign wr_en  = push && (!full || pop);
  assign drop_d = push && full && !pop;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  assign o_word       = (count_q != '0) ? mem[rd_ptr] : '0;
  assign o_word_valid = (count_q != '0);
  assign o_count      = count_q;
  assign o_drop       = drop_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// tb/tb_rx_word_packer.sv - directed bench for rx_word_packer with a queue-based reference model
module tb_rx_word_packer;

  localparam int TT = 8;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_tick = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_word_ready = 1'b0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [2:0]  o_count;
  logic        o_drop;
  logic        o_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mq[$];
  logic [7:0]  part[$];
  int          ticks = 0;
  logic        e_drop = 1'b0;
  logic        e_to = 1'b0;

  always #5 i_clk = ~i_clk;

  rx_word_packer #(.NB_DATA(8), .NB_WORD(32), .FIFO_DEPTH(4), .TIMEOUT_TICKS(TT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_data(i_data),
    .i_valid(i_valid), .i_flush(i_flush), .o_word(o_word), .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready), .o_count(o_count), .o_drop(o_drop), .o_timeout(o_timeout)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: bytes accumulate in a list, words in a queue, ticks counted since the last byte.
  initial forever begin
    logic        do_pop;
    logic        done;
    logic [31:0] w;
    @(posedge i_clk or negedge i_reset);
    if (!i_reset) begin
      mq.delete();
      part.delete();
      ticks  = 0;
      e_drop = 1'b0;
      e_to   = 1'b0;
    end else begin
      do_pop = (mq.size() > 0) && i_word_ready;
      e_drop = 1'b0;
      e_to   = 1'b0;
      done   = 1'b0;
      w      = 32'h0;
      if (i_flush) begin
        mq.delete();
        part.delete();
        ticks = 0;
      end else begin
        if (i_valid) begin
          part.push_back(i_data);
          ticks = 0;
          if (part.size() == 4) begin
            for (int k = 0; k < 4; k++) w = w | (32'(part[k]) << (8 * k));
            part.delete();
            done = 1'b1;
          end
        end else if (part.size() > 0 && i_tick) begin
          ticks++;
          if (ticks == TT) begin
            part.delete();
            ticks = 0;
            e_to  = 1'b1;
          end
        end
        if (do_pop) void'(mq.pop_front());
        if (done) begin
          if (mq.size() < 4) mq.push_back(w);
          else e_drop = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (i_reset) begin
      chk("m_word",    o_word, (mq.size() > 0) ? mq[0] : 32'h0);
      chk("m_valid",   32'(o_word_valid), 32'(mq.size() > 0));
      chk("m_count",   32'(o_count), 32'(mq.size()));
      chk("m_drop",    32'(o_drop), 32'(e_drop));
      chk("m_timeout", 32'(o_timeout), 32'(e_to));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    step();
    i_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick = 1'b1;
      step();
    end
    i_tick = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk(name, o_word, exp);
    i_word_ready = 1'b1;
    step();
    i_word_ready = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_word"}, o_word, 32'h0);
    chk({name, "_valid"}, 32'(o_word_valid), 32'h0);
    chk({name, "_count"}, 32'(o_count), 32'h0);
    chk({name, "_drop"}, 32'(o_drop), 32'h0);
    chk({name, "_timeout"}, 32'(o_timeout), 32'h0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    step();

    // Basic packing and single pop
    send_word(32'h12345678);
    chk("t1_word", o_word, 32'h12345678);
    chk("t1_valid", 32'(o_word_valid), 32'h1);
    chk("t1_count", 32'(o_count), 32'h1);
    i_word_ready = 1'b1;
    step();
    i_word_ready = 1'b0;
    chk("t1_count_after", 32'(o_count), 32'h0);
    chk("t1_word_after", o_word, 32'h0);

    // Overflow: fifth word dropped
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    chk("t2_nodrop", 32'(o_drop), 32'h0);
    send_word(32'h5);
    chk("t2_drop", 32'(o_drop), 32'h1);
    chk("t2_count", 32'(o_count), 32'h4);
    step();
    chk("t2_drop_once", 32'(o_drop), 32'h0);
    for (int i = 1; i <= 4; i++) pop_chk("t2_pop", 32'(i));
    chk("t2_empty", 32'(o_count), 32'h0);

    // Full FIFO, completion coincides with a pop
    for (int i = 0; i < 4; i++) send_word(32'h11 + 32'(i));
    send_byte(8'h15);
    send_byte(8'h00);
    send_byte(8'h00);
    i_word_ready = 1'b1;
    send_byte(8'h00);
    i_word_ready = 1'b0;
    chk("t3_nodrop", 32'(o_drop), 32'h0);
    chk("t3_count", 32'(o_count), 32'h4);
    pop_chk("t3_pop", 32'h12);
    pop_chk("t3_pop", 32'h13);
    pop_chk("t3_pop", 32'h14);
    pop_chk("t3_pop", 32'h15);

    // Inter-byte timeout discards a partial word
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick_n(TT - 1);
    chk("t4_no_early_to", 32'(o_timeout), 32'h0);
    tick_n(1);
    chk("t4_timeout", 32'(o_timeout), 32'h1);
    chk("t4_count", 32'(o_count), 32'h0);
    step();
    chk("t4_to_once", 32'(o_timeout), 32'h0);
    send_word(32'h04030201);
    chk("t4_word", o_word, 32'h04030201);
    pop_chk("t4_pop", 32'h04030201);

    // Byte on the final timeout tick wins
    send_byte(8'h0A);
    tick_n(TT - 1);
    i_tick = 1'b1;
    send_byte(8'h0B);
    i_tick = 1'b0;
    chk("t5_no_to", 32'(o_timeout), 32'h0);
    tick_n(3);
    send_byte(8'h0C);
    send_byte(8'h0D);
    chk("t5_word", o_word, 32'h0D0C0B0A);
    chk("t5_count", 32'(o_count), 32'h1);
    pop_chk("t5_pop", 32'h0D0C0B0A);

    // Asynchronous reset mid-word with words queued
    send_word(32'h21);
    send_word(32'h22);
    send_byte(8'hA1);
    send_byte(8'hA2);
    #2;
    i_reset = 1'b0;
    #1;
    chk_zero("t6_async");
    step();
    i_reset = 1'b1;
    step();
    send_word(32'h31323334);
    chk("t6_word", o_word, 32'h31323334);
    chk("t6_count", 32'(o_count), 32'h1);
    pop_chk("t6_pop", 32'h31323334);

    // Same with flush
    send_word(32'h41);
    send_word(32'h42);
    send_byte(8'hB1);
    send_byte(8'hB2);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk_zero("t7_flush");
    send_word(32'h51525354);
    chk("t7_word", o_word, 32'h51525354);
    chk("t7_count", 32'(o_count), 32'h1);
    pop_chk("t7_pop", 32'h51525354);

    // Flush on the completing byte discards the word
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    i_flush = 1'b1;
    send_byte(8'hC4);
    i_flush = 1'b0;
    chk_zero("t8_flush_done");
    send_word(32'h61626364);
    chk("t8_word", o_word, 32'h61626364);
    pop_chk("t8_pop", 32'h61626364);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_word_packer.md
# rx_word_packer

Downstream consumer of the UART receiver. Collects the byte stream delivered as one-cycle `valid` pulses and packs consecutive bytes, little-endian, into `NB_WORD`-bit words. Completed words go into a small FIFO read over a valid/ready handshake by the debug/command logic. An inter-byte timeout, counted in baud ticks, discards partial words so a lost byte cannot misalign every following word.

## Interface
Parameters:
- `NB_DATA`, 8: byte width; matches the receiver data width.
- `NB_WORD`, 32: output word width; must be a multiple of `NB_DATA`. `NB_BYTES = NB_WORD/NB_DATA` (default 4).
- `FIFO_DEPTH`, 4: word FIFO depth; must be a power of 2, at least 2.
- `TIMEOUT_TICKS`, 1024: number of `i_tick` pulses without a new byte after which a partial word is discarded.

Ports:
- `i_clk`, in, 1: single clock. All logic runs on its rising edge.
- `i_reset`, in, 1: reset is asynchronous and active-low; `i_reset`=0 resets the block immediately.
- `i_tick`, in, 1: 16x-baud tick; the same strobe that drives the receiver.
- `i_data`, in, `NB_DATA`: received byte; sampled only when `i_valid`=1.
- `i_valid`, in, 1: one-cycle pulse per received byte; every cycle it is high counts as one byte.
- `i_flush`, in, 1: synchronous clear of the packer, the timer and the FIFO.
- `o_word`, out, `NB_WORD`: FIFO head word; 0 when the FIFO is empty.
- `o_word_valid`, out, 1: FIFO is not empty.
- `i_word_ready`, in, 1: consumer pops the head when `o_word_valid` and `i_word_ready` are both 1.
- `o_count`, out, log2(`FIFO_DEPTH`)+1: FIFO occupancy.
- `o_drop`, out, 1: one-cycle pulse; a completed word was lost because the FIFO was full.
- `o_timeout`, out, 1: one-cycle pulse; a partial word was discarded.

## Operation
- State machine:
  - IDLE: byte index is 0 and the timer is stopped.
  - COLLECT: 1 to `NB_BYTES-1` bytes are held.
- Byte k (k = 0 at the start of a word) is written to bits [k·NB_DATA+NB_DATA-1 : k·NB_DATA]. The first byte received is the LSB of the word.
- Transitions:
  - IDLE + `i_valid`: store byte 0, index ← 1, enter COLLECT. If `NB_BYTES`=1, push the word instead and stay in IDLE.
  - COLLECT + `i_valid`, not the last byte: store the byte, index+1, timer ← 0.
  - COLLECT + `i_valid` on the last byte: the word is formed from the held bytes plus `i_data` in the same cycle and pushed. Index ← 0, timer ← 0, enter IDLE.
  - COLLECT, no `i_valid`, `i_tick`=1: timer+1. When the timer equals `TIMEOUT_TICKS-1` on a tick, clear the held bytes, index ← 0, pulse `o_timeout`, enter IDLE.
- Timer width is log2(`TIMEOUT_TICKS`)+1 bits and it never wraps. In IDLE it is held at 0.
- FIFO: write pointer, read pointer and count registers; pointers wrap modulo `FIFO_DEPTH`. `o_word` is driven combinationally from the head entry, forced to 0 when the count is 0.
- Push when full:
  - Without a pop in the same cycle, the word is discarded, `o_drop` pulses and the FIFO is unchanged.
  - With a pop in the same cycle, both the push and the pop happen, the count stays at `FIFO_DEPTH` and no drop is reported.
- Pop when empty is ignored.
- Priority, highest first: reset, then `i_flush`, then byte acceptance, then timeout.
  - A byte arriving in the same cycle as the final timeout tick is accepted and the timeout does not fire.
  - `i_flush` discards any word being completed in the same cycle; it is neither pushed nor reported as a drop.

## Timing
- Reset (asynchronous, `i_reset`=0): IDLE, index 0, timer 0, pointers 0, `o_count`=0, `o_word`=0, `o_word_valid`=0, `o_drop`=0, `o_timeout`=0.
  - Reset takes effect mid-word or mid-handshake without waiting for a clock edge.
- Latency: last byte `i_valid` at edge n → word in the FIFO after edge n. `o_word_valid`=1 during cycle n+1 if the FIFO was empty.
- A pop at edge m updates `o_word` and `o_count` in cycle m+1. Back-to-back pops deliver one word per cycle.
- `o_drop` and `o_timeout` are registered: they are high for exactly the one cycle after the edge on which the event occurred.
- `i_flush` at edge f: all state cleared, and all outputs read 0 in cycle f+1.

## Test plan
- `i_word_ready`=0, bytes 0x78, 0x56, 0x34, 0x12 → one cycle after the 4th `i_valid`: `o_word`=0x12345678, `o_word_valid`=1, `o_count`=1. Pulse `i_word_ready` once → `o_count`=0, `o_word`=0.
- 5 words 0x00000001..0x00000005 with ready=0 → `o_count`=4, `o_drop` pulses once on the 5th word. Popping then returns 1, 2, 3, 4 in order.
- FIFO full, 4th byte of a new word coincides with a pop → no `o_drop`, `o_count` stays 4, the new word appears after the remaining 3.
- Bytes 0xAA, 0xBB, then `TIMEOUT_TICKS` ticks with no byte → `o_timeout` pulses once and no word is pushed. Next bytes 0x01, 0x02, 0x03, 0x04 → `o_word`=0x04030201.
- 2nd byte `i_valid` on the same cycle as the final timeout tick → no `o_timeout`. Two more bytes complete the word normally.
- `i_reset`=0 asserted mid-word (2 bytes held) with 2 words queued → all outputs 0 at once without a clock edge. After release, 4 bytes yield exactly one correct word. Repeat the same sequence using `i_flush` instead of reset.
